// File: rtl/multiword_add_sub_seq.sv
// Multi-word add/sub: one M-bit slice sequenced over K chunks, LSB chunk first, carry chained via register.
// Latency: accept at edge t0, out_valid after edge t0+K; one operation in flight.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready. Optional `zero` port: MWADD_ZERO_FLAG_EN.

module multiword_add_sub_slice #(
  parameter int M = 8
) (
  input  logic [M-1:0] a,
  input  logic [M-1:0] b,
  input  logic         sub,
  input  logic         cin,
  output logic [M-1:0] sum,
  output logic         cout,
  output logic         v
);
  logic [M-1:0] bx;
  logic [M-1:0] low;

  assign bx = b ^ {M{sub}};
  assign {cout, sum} = {1'b0, a} + {1'b0, bx} + {{M{1'b0}}, cin};
  // low[M-1] is the carry into the MSB; overflow is its disagreement with carry out
  assign low = {1'b0, a[M-2:0]} + {1'b0, bx[M-2:0]} + {{(M-1){1'b0}}, cin};
  assign v   = low[M-1] ^ cout;
endmodule

module multiword_add_sub_seq #(
  parameter int M = 8,
  parameter int K = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           sub,
  input  logic           cin,
  input  logic [M*K-1:0] a,
  input  logic [M*K-1:0] b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [M*K-1:0] result,
  output logic           cout,
  output logic           v,
  output logic           busy
`ifdef MWADD_ZERO_FLAG_EN
  ,
  output logic           zero
`endif
);
  localparam int W  = M * K;
  localparam int IW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nxt;
  logic [W-1:0]  a_q, b_q;
  logic          carry_q;
  logic [IW-1:0] idx;
  logic          accept, last;
  logic [M-1:0]  s_a, s_b, s_sum;
  logic          s_cout, s_v;

  assign accept = in_valid & in_ready;
  assign last   = (idx == IW'(K - 1));
  assign s_a    = a_q[idx*M +: M];
  assign s_b    = b_q[idx*M +: M];

  // Subtract inversion already lives in b_q, so the slice only ever adds
  multiword_add_sub_slice #(.M(M)) u_slice (
    .a    (s_a),
    .b    (s_b),
    .sub  (1'b0),
    .cin  (carry_q),
    .sum  (s_sum),
    .cout (s_cout),
    .v    (s_v)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx     <= '0;
      result  <= '0;
      cout    <= 1'b0;
      v       <= 1'b0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= sub ? ~b : b;
      carry_q <= sub | cin;
      idx     <= '0;
    end else if (state == RUN) begin
      result[idx*M +: M] <= s_sum;
      carry_q            <= s_cout;
      idx                <= idx + 1'b1;
      if (last) begin
        cout <= s_cout;
        v    <= s_v;
      end
    end
  end

`ifdef MWADD_ZERO_FLAG_EN
  logic zero_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             zero_q <= 1'b0;
    else if (accept)        zero_q <= 1'b1;
    else if (state == RUN)  zero_q <= zero_q & (s_sum == '0);
  end

  assign zero = zero_q;
`endif

endmodule

// File: tb/tb_multiword_add_sub_seq.sv
// Randomized and directed bench for multiword_add_sub_seq (M=8, K=4) against a whole-word arithmetic model.

module tb_multiword_add_sub_seq;
  localparam int M = 8;
  localparam int K = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        sub = 1'b0;
  logic        cin = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        cout;
  logic        v;
  logic        busy;
`ifdef MWADD_ZERO_FLAG_EN
  logic        zero;
`endif

  multiword_add_sub_seq #(.M(M), .K(K)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sub       (sub),
    .cin       (cin),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .v         (v),
    .busy      (busy)
`ifdef MWADD_ZERO_FLAG_EN
    ,
    .zero      (zero)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] r;
    logic        c;
    logic        ov;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   acc_cyc = 0;
  bit   first = 0;

  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic s, input logic ci);
    exp_t e;
    logic [32:0] full;
    if (s) full = {1'b0, x} + {1'b0, ~y} + 33'd1;
    else   full = {1'b0, x} + {1'b0, y} + {32'd0, ci};
    e.r  = full[31:0];
    e.c  = full[32];
    if (s) e.ov = (x[31] != y[31]) && (e.r[31] != x[31]);
    else   e.ov = (x[31] == y[31]) && (e.r[31] != x[31]);
    return e;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (rst_n && in_valid && in_ready) begin
      q.push_back(model(a, b, sub, cin));
      acc_cyc = cyc;
      first = 1;
    end
    if (rst_n && out_valid && out_ready && q.size() > 0) void'(q.pop_front());
  end

  always @(negedge rst_n) q.delete();

  always @(negedge clk) begin
    if (rst_n) begin
      chk("ready_vs_busy", in_ready, !busy);
      if (out_valid) begin
        if (q.size() == 0) chk("spurious_out_valid", 1, 0);
        else begin
          chk("result", result, q[0].r);
          chk("cout", cout, q[0].c);
          chk("v", v, q[0].ov);
`ifdef MWADD_ZERO_FLAG_EN
          chk("zero", zero, q[0].r == 32'd0);
`endif
          if (first) begin
            chk("latency", cyc - acc_cyc, K);
            first = 0;
          end
        end
      end
    end
  end

  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_b, input logic ts, input logic tc,
                        input int hold, input logic keep_valid,
                        output logic [31:0] r, output logic co, output logic vo, output logic zo);
    int n;
    r = '0; co = 1'b0; vo = 1'b0; zo = 1'b0;
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    a = ta; b = tb_b; sub = ts; cin = tc; in_valid = 1'b1; out_ready = (hold == 0);
    @(negedge clk);
    in_valid = keep_valid;
    if (keep_valid) begin a = $urandom; b = $urandom; end
    n = 0;
    while (!out_valid && n < 20) begin @(negedge clk); n++; end
    if (!out_valid) begin
      chk("done_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    r = result; co = cout; vo = v;
`ifdef MWADD_ZERO_FLAG_EN
    zo = zero;
`endif
    for (int i = 0; i < hold; i++) begin
      chk("bp_in_ready", in_ready, 0);
      chk("bp_result_stable", result, r);
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("idle_after_done", {out_valid, in_ready, busy}, 3'b010);
  endtask

  logic [31:0] r;
  logic        co, vo, zo;

  initial begin
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_result", result, 0);
    chk("rst_cout_v", {cout, v}, 2'b00);
    #22 rst_n = 1'b1;

    run_op(32'hFFFFFFFF, 32'h00000001, 0, 0, 0, 0, r, co, vo, zo);
    chk("t1_result", r, 32'h0);
    chk("t1_cout_v", {co, vo}, 2'b10);

    run_op(32'h7FFFFFFF, 32'h00000001, 0, 0, 0, 0, r, co, vo, zo);
    chk("t2_result", r, 32'h80000000);
    chk("t2_cout_v", {co, vo}, 2'b01);
    run_op(32'h1, 32'h1, 0, 1, 0, 0, r, co, vo, zo);
    chk("t2_cin_result", r, 32'h3);

    run_op(32'h5, 32'h7, 1, 0, 0, 0, r, co, vo, zo);
    chk("t3_result", r, 32'hFFFFFFFE);
    chk("t3_cout_v", {co, vo}, 2'b00);
    run_op(32'h80000000, 32'h1, 1, 1, 0, 0, r, co, vo, zo);
    chk("t3b_result", r, 32'h7FFFFFFF);
    chk("t3b_cout_v", {co, vo}, 2'b11);

    run_op(32'hDEADBEEF, 32'h01234567, 0, 1, 10, 1, r, co, vo, zo);
    chk("t4_result", r, 32'hDFD10457);

    // abort during chunk 2
    @(negedge clk);
    a = 32'hCAFEF00D; b = 32'h12345678; sub = 0; cin = 0; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_result", result, 0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("post_abort_idle", {out_valid, in_ready, busy}, 3'b010);
    run_op(32'h00010000, 32'h0000FFFF, 0, 0, 0, 0, r, co, vo, zo);
    chk("t5_result", r, 32'h0001FFFF);

`ifdef MWADD_ZERO_FLAG_EN
    run_op(32'h12345678, 32'h12345678, 1, 0, 0, 0, r, co, vo, zo);
    chk("t6_result", r, 32'h0);
    chk("t6_zero_cout", {zo, co}, 2'b11);
    run_op(32'h0, 32'h1, 0, 0, 0, 0, r, co, vo, zo);
    chk("t6b_zero", zo, 0);
`endif

    for (int i = 0; i < 40; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = (i % 8 == 0) ? ra : $urandom;
      run_op(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             $urandom_range(0, 3), 1'($urandom_range(0, 1)), r, co, vo, zo);
    end

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
